// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, controller
// states and status-flag bit positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier core: load latches the operands, each step
// retires one multiplier bit, last flags the step that completes the product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product_nxt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // The low half starts as the multiplier and fills with product bits as it shifts.
    always_comb begin
        sum         = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        product_nxt = {sum, lo_q[WIDTH-1:1]};
        last        = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (load) begin
            mcand_d = a;
            hi_d    = '0;
            lo_d    = b;
            cnt_d   = '0;
        end else if (step) begin
            {hi_d, lo_d} = product_nxt;
            cnt_d        = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, multi-cycle multiply,
// registered result and {V,N,C,Z} flags, output-enabled bus drive.
//   state   | meaning
//   ST_IDLE | accepting start; non-MUL ops complete at the start edge
//   ST_MUL  | multiplier stepping, start ignored, busy high
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [2:0]       op_select,
    input  logic             start,
    input  logic             alu_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] data_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags, mul_flags;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (mul_load),
        .step        (mul_step),
        .a           (reg_a),
        .b           (reg_b),
        .last        (mul_last),
        .product_nxt (mul_prod)
    );

    // Extended add/sub so the top bit is carry out (ADD) or borrow (SUB).
    always_comb begin
        ext   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op_select)
            OP_ADD: begin
                ext   = {1'b0, reg_a} + {1'b0, reg_b};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (alu_r[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, reg_a} - {1'b0, reg_b};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (alu_r[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_OR:  alu_r = reg_a | reg_b;
            OP_AND: alu_r = reg_a & reg_b;
            OP_XOR: alu_r = reg_a ^ reg_b;
            OP_SHL: begin
                alu_r = {reg_a[WIDTH-2:0], 1'b0};
                alu_c = reg_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, reg_a[WIDTH-1:1]};
                alu_c = reg_a[0];
            end
            default: alu_r = '0;
        endcase

        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_r == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_N] = alu_r[WIDTH-1];
        alu_flags[FLAG_V] = alu_v;

        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod == '0);
        mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_select == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = alu_r;
                        result_hi_d = '0;
                        flags_d     = alu_flags;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d    = mul_prod[WIDTH-1:0];
                    result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d     = mul_flags;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == ST_MUL);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign data_out  = alu_out ? result_q : '0;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] reg_a = '0;
    logic [W-1:0] reg_b = '0;
    logic [2:0]   op_select = '0;
    logic         start = 1'b0;
    logic         alu_out = 1'b1;
    logic         busy, done;
    logic [W-1:0] result, result_hi, data_out;
    logic [3:0]   flags;

    int total = 0;
    int bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .op_select (op_select),
        .start     (start),
        .alu_out   (alu_out),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: flags packed {V,N,C,Z}, computed from integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [7:0] hi, output logic [3:0] fl);
        int ai, bi, sa, sb, s, sv, p;
        bit z, c, n, v;
        ai = a; bi = b;
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        c = 0; v = 0; hi = 0; s = 0;
        case (op)
            3'd0: begin s = ai + bi; c = (s > 255); sv = sa + sb; v = (sv > 127) || (sv < -128); end
            3'd1: begin s = ai - bi + 256; c = (ai < bi); sv = sa - sb; v = (sv > 127) || (sv < -128); end
            3'd2: s = ai | bi;
            3'd3: s = ai & bi;
            3'd4: s = ai ^ bi;
            3'd5: begin s = ai * 2; c = (ai >= 128); end
            3'd6: begin s = ai / 2; c = (ai % 2) == 1; end
            default: begin
                p = ai * bi;
                s = p % 256;
                hi = 8'(p / 256);
                c = (p / 256) != 0;
            end
        endcase
        r = 8'(s % 256);
        n = (r >= 128);
        z = (op == 3'd7) ? (ai * bi == 0) : (r == 0);
        fl = {v, n, c, z};
    endfunction

    // noise=1 keeps an ADD start request asserted throughout a MUL, final edge included.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit noise);
        logic [7:0] er, eh;
        logic [3:0] ef;
        model(op, a, b, er, eh, ef);
        op_select = op; reg_a = a; reg_b = b; start = 1'b1;
        tick();
        if (op == 3'd7) begin
            chk("mul_busy_first", busy, 1);
            chk("mul_no_early_done", done, 0);
            if (noise) begin
                op_select = 3'd0; reg_a = 8'h01; reg_b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            for (int k = 1; k < W; k++) begin
                tick();
                chk("mul_busy", busy, 1);
                chk("mul_done_low", done, 0);
            end
            tick();
            chk("mul_busy_end", busy, 0);
            chk("mul_done", done, 1);
        end else begin
            chk("op_done", done, 1);
            chk("op_busy", busy, 0);
        end
        start = 1'b0;
        chk("result", result, er);
        chk("result_hi", result_hi, eh);
        chk("flags", flags, ef);
        chk("data_out", data_out, alu_out ? er : 8'h00);
        tick();
        chk("done_pulse", done, 0);
        chk("result_hold", result, er);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_flags", flags, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(3'd0, 8'h7F, 8'h01, 0);
        chk("add_flags_vn", flags, 4'b1100);
        run_op(3'd1, 8'h05, 8'h07, 0);
        chk("sub_flags_nc", flags, 4'b0110);
        run_op(3'd1, 8'h10, 8'h10, 0);
        chk("sub_flags_z", flags, 4'b0001);
        run_op(3'd5, 8'h81, 8'h00, 0);
        chk("shl_res", result, 8'h02);
        run_op(3'd7, 8'hFF, 8'hFF, 0);
        chk("mul_lo", result, 8'h01);
        chk("mul_hi", result_hi, 8'hFE);
        run_op(3'd7, 8'h0F, 8'h11, 0);
        chk("mul2_lo", result, 8'hFF);
        chk("mul2_flags", flags, 4'b0100);
        run_op(3'd7, 8'h03, 8'h05, 1);
        chk("mul_noise_res", result, 8'h0F);

        // start held high: back-to-back results, done stays high
        op_select = 3'd0; reg_a = 8'h01; reg_b = 8'h01; start = 1'b1;
        tick();
        chk("b2b_res1", result, 8'h02);
        chk("b2b_done1", done, 1);
        op_select = 3'd4; reg_a = 8'hF0; reg_b = 8'h0F;
        tick();
        chk("b2b_res2", result, 8'hFF);
        chk("b2b_done2", done, 1);
        chk("b2b_flags2", flags, 4'b0100);
        start = 1'b0;
        tick();

        // reset in the middle of a multiply
        op_select = 3'd7; reg_a = 8'h33; reg_b = 8'h44; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_hi", result_hi, 0);
        chk("arst_flags", flags, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(3'd0, 8'h02, 8'h03, 0);
        chk("post_rst_add", result, 8'h05);

        // output gating is combinational
        alu_out = 1'b0;
        run_op(3'd2, 8'h5A, 8'h00, 0);
        chk("gate_off", data_out, 8'h00);
        alu_out = 1'b1;
        #1;
        chk("gate_on", data_out, 8'h5A);

        for (int i = 0; i < 40; i++) begin
            alu_out = 1'($urandom_range(0, 1));
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
